axis_eth_fcs_insert: RTL and testbench

AXIS_ETH_FCS_INSERT -- requirements
Module: axis_eth_fcs_insert

---
 rtl/axis_eth_fcs_insert.sv | 178 +++++++++++++++++
 tb/tb_axis_eth_fcs_insert.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_eth_fcs_insert.sv
// Appends the Ethernet FCS (CRC-32) to 8-bit AXI-Stream frames behind a 2-entry skid buffer.
// Define AXIS_ETH_FCS_INSERT_PAD_EN to zero-pad short frames up to MIN_FRAME_LENGTH.
module axis_eth_fcs_insert #(
    parameter int unsigned MIN_FRAME_LENGTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy
);

`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, FCS} state_t;
    localparam logic [15:0] MinPayload = 16'(MIN_FRAME_LENGTH - 4);
`else
    typedef enum logic [1:0] {IDLE, PAYLOAD, FCS} state_t;
`endif

    // Reflected CRC-32 (poly 0x04C11DB7), one byte per call
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_cur, fcs_word;
    logic [15:0] cnt_q, cnt_d, cnt_cur, cnt_next;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        user_q, user_d;
    logic        s_ready_q, busy_q;
    logic        s_fire;

    logic [7:0]  int_tdata;
    logic        int_tvalid, int_tlast, int_tuser;
    logic        int_tready_q, int_tready_early;

    logic [7:0]  out_tdata_q, tmp_tdata_q;
    logic        out_tvalid_q, out_tlast_q, out_tuser_q;
    logic        tmp_tvalid_q, tmp_tlast_q, tmp_tuser_q;

    assign s_fire   = s_axis_tvalid && s_ready_q;
    assign crc_cur  = (state_q == IDLE) ? 32'hFFFFFFFF : crc_q;
    assign cnt_cur  = (state_q == IDLE) ? 16'd0 : cnt_q;
    assign cnt_next = (cnt_cur == 16'hFFFF) ? cnt_cur : cnt_cur + 16'd1;
    assign fcs_word = ~crc_q;

    // Skid buffer can take a byte next cycle if the sink is ready or the temp slot stays free
    assign int_tready_early = m_axis_tready || (!tmp_tvalid_q && (!out_tvalid_q || !int_tvalid));

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        fcs_idx_d  = fcs_idx_q;
        user_d     = user_q;
        int_tdata  = 8'd0;
        int_tvalid = 1'b0;
        int_tlast  = 1'b0;
        int_tuser  = 1'b0;
        unique case (state_q)
            IDLE, PAYLOAD: begin
                if (state_q == IDLE) begin
                    crc_d = 32'hFFFFFFFF;
                    cnt_d = 16'd0;
                end
                if (s_fire) begin
                    int_tdata  = s_axis_tdata;
                    int_tvalid = 1'b1;
                    crc_d      = crc_byte(crc_cur, s_axis_tdata);
                    cnt_d      = cnt_next;
                    state_d    = PAYLOAD;
                    if (s_axis_tlast) begin
                        user_d    = s_axis_tuser;
                        fcs_idx_d = 2'd0;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
                        state_d   = (cnt_next < MinPayload) ? PAD : FCS;
`else
                        state_d   = FCS;
`endif
                    end
                end
            end
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
            PAD: begin
                if (int_tready_q) begin
                    int_tvalid = 1'b1;
                    crc_d      = crc_byte(crc_q, 8'h00);
                    cnt_d      = cnt_next;
                    if (cnt_next >= MinPayload) state_d = FCS;
                end
            end
`endif
            FCS: begin
                if (int_tready_q) begin
                    int_tdata  = fcs_word[{fcs_idx_q, 3'b000} +: 8];
                    int_tvalid = 1'b1;
                    fcs_idx_d  = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        int_tlast = 1'b1;
                        int_tuser = user_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_q        <= 32'hFFFFFFFF;
            cnt_q        <= 16'd0;
            fcs_idx_q    <= 2'd0;
            user_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            int_tready_q <= 1'b0;
            out_tdata_q  <= 8'd0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            out_tuser_q  <= 1'b0;
            tmp_tdata_q  <= 8'd0;
            tmp_tvalid_q <= 1'b0;
            tmp_tlast_q  <= 1'b0;
            tmp_tuser_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            fcs_idx_q    <= fcs_idx_d;
            user_q       <= user_d;
            s_ready_q    <= int_tready_early && (state_d == IDLE || state_d == PAYLOAD);
            busy_q       <= (state_d != IDLE);
            int_tready_q <= int_tready_early;
            if (int_tready_q) begin
                if (m_axis_tready || !out_tvalid_q) begin
                    out_tvalid_q <= int_tvalid;
                    out_tdata_q  <= int_tdata;
                    out_tlast_q  <= int_tlast;
                    out_tuser_q  <= int_tuser;
                end else begin
                    tmp_tvalid_q <= int_tvalid;
                    tmp_tdata_q  <= int_tdata;
                    tmp_tlast_q  <= int_tlast;
                    tmp_tuser_q  <= int_tuser;
                end
            end else if (m_axis_tready) begin
                out_tvalid_q <= tmp_tvalid_q;
                out_tdata_q  <= tmp_tdata_q;
                out_tlast_q  <= tmp_tlast_q;
                out_tuser_q  <= tmp_tuser_q;
                tmp_tvalid_q <= 1'b0;
            end
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = out_tdata_q;
    assign m_axis_tvalid = out_tvalid_q;
    assign m_axis_tlast  = out_tlast_q;
    assign m_axis_tuser  = out_tuser_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_eth_fcs_insert.sv
// Bench for axis_eth_fcs_insert: directed and randomized frames checked against a
// queue-based reference model (padding follows AXIS_ETH_FCS_INSERT_PAD_EN).
`timescale 1ns/1ps
module tb_axis_eth_fcs_insert;
    localparam int unsigned MinFrame = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0, s_last = 1'b0, s_user = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_user;
    logic       m_ready = 1'b0;
    logic       busy;

    axis_eth_fcs_insert #(.MIN_FRAME_LENGTH(MinFrame)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_data),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tlast (s_last),
        .s_axis_tuser (s_user),
        .m_axis_tdata (m_data),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast (m_last),
        .m_axis_tuser (m_user),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    bit         rand_ready = 1'b0;
    int         gap_pct = 0;
    logic [9:0] out_q[$];  // {tuser, tlast, tdata} in arrival order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-32 of the whole message, returned as the transmitted FCS value
    function automatic logic [31:0] ref_fcs(input logic [7:0] msg[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ msg[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic void build_expected(input logic [7:0] pay[$], input logic user,
                                           output logic [9:0] exp[$]);
        logic [7:0]  msg[$];
        logic [31:0] fcs;
        msg = pay;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
        while (msg.size() < MinFrame - 4) msg.push_back(8'h00);
`endif
        fcs = ref_fcs(msg);
        exp.delete();
        foreach (msg[i]) exp.push_back({2'b00, msg[i]});
        for (int k = 0; k < 4; k++) exp.push_back({(k == 3) ? user : 1'b0, k == 3, fcs[8*k +: 8]});
    endfunction

    // One cycle: sink decides tready; a handshake visible now completes at the next rising edge
    task automatic tick();
        @(negedge clk);
        m_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
        if (!rst && m_valid && m_ready) out_q.push_back({m_user, m_last, m_data});
    endtask

    task automatic after_first(input logic [7:0] b0, input bit chk_lat);
        check("busy_after_first", {31'd0, busy}, 32'd1);
        if (chk_lat) begin
            check("first_out_valid", {31'd0, m_valid}, 32'd1);
            check("first_out_data", {24'd0, m_data}, {24'd0, b0});
        end
    endtask

    task automatic send_frame(input logic [7:0] pay[$], input logic user, input bit chk_lat);
        int i     = 0;
        int guard = 0;
        bit fresh = 1'b0;
        while (i < pay.size()) begin
            tick();
            if (fresh) begin
                after_first(pay[0], chk_lat);
                fresh = 1'b0;
            end
            if (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_user  = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = pay[i];
                s_last  = (i == pay.size() - 1);
                s_user  = s_last ? user : 1'($urandom_range(1));
            end
            if (s_valid && s_ready) begin
                if (i == 0) fresh = 1'b1;
                i++;
            end
            guard++;
            if (guard > 20000) begin
                check("input_timeout", 32'(i), 32'(pay.size()));
                break;
            end
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        if (fresh) after_first(pay[0], chk_lat);
    endtask

    task automatic finish_frame(input string tag, input logic [9:0] exp[$]);
        int guard   = 0;
        bit tail_rd = 1'b0;
        int n;
        while (out_q.size() < exp.size() && guard < 20000) begin
            tick();
            if (busy && s_ready) tail_rd = 1'b1;
            guard++;
        end
        for (int k = 0; k < 6; k++) tick();
        check({tag, "_tail_ready"}, {31'd0, tail_rd}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_len"}, 32'(out_q.size()), 32'(exp.size()));
        n = (out_q.size() < exp.size()) ? out_q.size() : exp.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_byte%0d", tag, k), {22'd0, out_q[k]}, {22'd0, exp[k]});
        out_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] pay[$], input logic user,
                             input bit chk_lat);
        logic [9:0] exp[$];
        build_expected(pay, user, exp);
        send_frame(pay, user, chk_lat);
        finish_frame(tag, exp);
    endtask

    function automatic void rand_payload(input int n, output logic [7:0] pay[$]);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] pay[$];
        logic [9:0] exp[$];
        int         n;

        // Reset values
        rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_m_user", {31'd0, m_user}, 32'd0);
        rst = 1'b0;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        tick();

        // "123456789" check value
        pay.delete();
        for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
        build_expected(pay, 1'b0, exp);
`else
        exp.delete();
        foreach (pay[k]) exp.push_back({2'b00, pay[k]});
        exp.push_back(10'h026);
        exp.push_back(10'h039);
        exp.push_back(10'h0F4);
        exp.push_back(10'h1CB);
`endif
        send_frame(pay, 1'b0, 1'b1);
        finish_frame("kat", exp);

        // Bad-frame marker, single-byte frame, padding boundaries, maximum length
        rand_payload(20, pay);
        run_frame("tuser20", pay, 1'b1, 1'b1);
        rand_payload(1, pay);
        run_frame("one_byte", pay, 1'b0, 1'b1);
        rand_payload(10, pay);
        run_frame("len10", pay, 1'b0, 1'b1);
        rand_payload(59, pay);
        run_frame("len59", pay, 1'b0, 1'b0);
        rand_payload(60, pay);
        run_frame("len60", pay, 1'b0, 1'b0);
        rand_payload(61, pay);
        run_frame("len61", pay, 1'b1, 1'b0);
        rand_payload(1500, pay);
        run_frame("len1500", pay, 1'b0, 1'b0);

        // Random back-pressure and input gaps
        rand_ready = 1'b1;
        gap_pct    = 30;
        for (int f = 0; f < 100; f++) begin
            n = ($urandom_range(11) == 0) ? int'($urandom_range(1500, 1)) : int'($urandom_range(64, 1));
            rand_payload(n, pay);
            run_frame($sformatf("rnd%0d", f), pay, 1'($urandom_range(1)), 1'b0);
        end

        // Reset after 5 bytes, then a clean 3-byte frame
        rand_ready = 1'b0;
        gap_pct    = 0;
        n          = 0;
        while (n < 5) begin
            tick();
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b0;
            s_user  = 1'b0;
            if (s_ready) n++;
        end
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        out_q.delete();
        tick();
        rand_payload(3, pay);
        run_frame("after_rst", pay, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
